fifo_drain_ctrl: RTL and testbench

- Consumer-side controller for the dual-SPRAM ping-pong FIFO. It is the reader that pairs with the FIFO's write side.
- Tracks FIFO occupancy from the producer's accepted writes, issues read strobes (RE), absorbs the variable read latency, and re-presents data as a valid/ready stream.
- Sits between the FIFO's DO/read_valid/r_err outputs and any downstream consumer (UART TX, bus master).

---
 rtl/fifo_pkg.sv | 17 +
 rtl/drain_obuf.sv | 45 ++++
 rtl/fifo_drain_ctrl.sv | 120 ++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the ping-pong FIFO drain controller: width defaults,
// FSM state encoding and statistics counter widths.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int STAT_WORDS_W   = 16;
  localparam int STAT_ERRS_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/drain_obuf.sv
// Circular output skid buffer for the drain controller; head entry is
// presented combinationally, push and pop in one cycle are both honoured.
module drain_obuf #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign data    = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= push_data;
        wp      <= wp + PW'(1);
      end
      if (pop_ok) rp <= rp + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Consumer-side drain controller for the ping-pong FIFO: credit-limited read
// issue, latency absorption and valid/ready output. Option: FIFO_DRAIN_STATS_EN.
//
// Handshake: a word moves downstream on every cycle where m_valid && m_ready
// are both high at the rising clk edge; m_valid never depends on m_ready.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int OBUF_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_evt,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  input  logic                  fifo_read_valid,
  input  logic                  fifo_r_err,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  clear_err,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  halted,
  output state_t                dbg_state
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [STAT_WORDS_W-1:0] stat_words,
  output logic [STAT_ERRS_W-1:0]  stat_errs
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int IW    = $clog2(MAX_INFLIGHT+1);
  localparam int CW    = $clog2(OBUF_DEPTH+1);
  localparam logic [ADDR_WIDTH:0] OCC_FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [ADDR_WIDTH:0]   occ;
  logic [IW-1:0]         inflight;
  logic [CW-1:0]         count;
  logic                  credit;
  logic                  occ_nz;
  logic                  rv_ok;
  logic                  err;
  logic                  wr_ok;

  // Credit counts words already requested so the skid buffer can never overflow.
  assign credit  = (inflight < IW'(MAX_INFLIGHT)) &&
                   ((int'(count) + int'(inflight)) < OBUF_DEPTH);
  assign occ_nz  = (occ != '0);
  assign fifo_re = (state == READ) && occ_nz && credit;
  assign rv_ok   = fifo_read_valid && (inflight != '0);
  assign err     = fifo_r_err || (fifo_read_valid && (inflight == '0));
  assign wr_ok   = wr_evt && ((occ != OCC_FULL) || fifo_re);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      occ      <= '0;
      inflight <= '0;
    end else begin
      occ      <= occ + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(fifo_re);
      inflight <= inflight + IW'(fifo_re) - IW'(rv_ok);
      if (err) begin
        state <= HALT;
      end else begin
        case (state)
          IDLE:  if (occ_nz) state <= READ;
          READ: begin
            if (occ_nz && !credit)                 state <= STALL;
            else if (!occ_nz && (inflight == '0))  state <= IDLE;
          end
          STALL: if (credit) state <= READ;
          HALT: begin
            if (clear_err && (inflight == '0)) begin
              state <= IDLE;
              occ   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  drain_obuf #(
    .DW    (DATA_WIDTH),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_read_valid),
    .push_data (fifo_do),
    .pop       (m_ready),
    .data      (m_data),
    .count     (count)
  );

  assign m_valid   = (count != '0);
  assign occupancy = occ;
  assign halted    = (state == HALT);
  assign dbg_state = state;

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_words <= '0;
      stat_errs  <= '0;
    end else begin
      if (m_valid && m_ready) stat_words <= stat_words + STAT_WORDS_W'(1);
      if (err && (state != HALT) && (stat_errs != {STAT_ERRS_W{1'b1}}))
        stat_errs <= stat_errs + STAT_ERRS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl with a 2-cycle-latency FIFO read model.
module tb_fifo_drain_ctrl;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_evt = 1'b0;
  logic       fifo_re;
  logic [7:0] fifo_do;
  logic       fifo_read_valid;
  logic       fifo_r_err = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [3:0] occupancy;
  logic       halted;
  state_t     dbg_state;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] stat_words;
  logic [7:0]  stat_errs;
`endif

  fifo_drain_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .wr_evt          (wr_evt),
    .fifo_re         (fifo_re),
    .fifo_do         (fifo_do),
    .fifo_read_valid (fifo_read_valid),
    .fifo_r_err      (fifo_r_err),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .clear_err       (clear_err),
    .occupancy       (occupancy),
    .halted          (halted),
    .dbg_state       (dbg_state)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .stat_words      (stat_words),
    .stat_errs       (stat_errs)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // FIFO read-side model: data returned two cycles after each RE
  logic [7:0] mem [16];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr;
  logic       p1_v, p2_v;
  logic [7:0] p1_d, p2_d;
  logic       force_rv = 1'b0;
  logic [7:0] force_d = 8'h00;
  int         re_cnt;

  always @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= 4'd0;
      p1_v   <= 1'b0;
      p2_v   <= 1'b0;
      p1_d   <= 8'h00;
      p2_d   <= 8'h00;
      re_cnt <= 0;
    end else begin
      p1_v <= fifo_re;
      p1_d <= mem[rd_ptr];
      if (fifo_re) begin
        rd_ptr <= rd_ptr + 4'd1;
        re_cnt <= re_cnt + 1;
      end
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end

  assign fifo_read_valid = p2_v | force_rv;
  assign fifo_do         = force_rv ? force_d : p2_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every downstream transfer must match the next written word
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", {24'h0, m_data}, 32'hFFFF_FFFF);
      else chk("sb_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic do_reset();
    rst = 1'b0;
    wr_evt = 1'b0;
    fifo_r_err = 1'b0;
    clear_err = 1'b0;
    force_rv = 1'b0;
    m_ready = 1'b0;
    wr_ptr = 4'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wr_word(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
    exp_q.push_back(d);
    wr_evt = 1'b1;
    @(posedge clk);
    #1 wr_evt = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && dbg_state == IDLE && occupancy == 4'd0 && !m_valid)
           && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, {31'h0, n < 200}, 32'h1);
  endtask

  typedef struct {
    int         nwr;
    logic       ready;
    logic [3:0] exp_occ;
    state_t     exp_state;
    int         exp_re;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{nwr: 3, ready: 1'b1, exp_occ: 4'd0, exp_state: IDLE,  exp_re: 3, exp_valid: 1'b0};
    vecs[1] = '{nwr: 8, ready: 1'b0, exp_occ: 4'd4, exp_state: STALL, exp_re: 4, exp_valid: 1'b1};
    vecs[2] = '{nwr: 1, ready: 1'b0, exp_occ: 4'd0, exp_state: IDLE,  exp_re: 1, exp_valid: 1'b1};
    vecs[3] = '{nwr: 2, ready: 1'b0, exp_occ: 4'd0, exp_state: IDLE,  exp_re: 2, exp_valid: 1'b1};
    vecs[4] = '{nwr: 5, ready: 1'b1, exp_occ: 4'd0, exp_state: IDLE,  exp_re: 5, exp_valid: 1'b0};
    vecs[5] = '{nwr: 0, ready: 1'b1, exp_occ: 4'd0, exp_state: IDLE,  exp_re: 0, exp_valid: 1'b0};

    do_reset();
    chk("rst_fifo_re",   {31'h0, fifo_re},   32'h0);
    chk("rst_m_valid",   {31'h0, m_valid},   32'h0);
    chk("rst_m_data",    {24'h0, m_data},    32'h0);
    chk("rst_occupancy", {28'h0, occupancy}, 32'h0);
    chk("rst_halted",    {31'h0, halted},    32'h0);
    chk("rst_state",     {30'h0, dbg_state}, {30'h0, IDLE});

    // table: burst of writes, settle, check, then release and drain
    for (int v = 0; v < 6; v++) begin
      do_reset();
      m_ready = vecs[v].ready;
      for (int i = 0; i < vecs[v].nwr; i++) wr_word(8'(8'hA1 + 8'h11 * i));
      cycles(30);
      chk($sformatf("v%0d_occ", v),    {28'h0, occupancy}, {28'h0, vecs[v].exp_occ});
      chk($sformatf("v%0d_state", v),  {30'h0, dbg_state}, {30'h0, vecs[v].exp_state});
      chk($sformatf("v%0d_re", v),     re_cnt,             vecs[v].exp_re);
      chk($sformatf("v%0d_valid", v),  {31'h0, m_valid},   {31'h0, vecs[v].exp_valid});
      chk($sformatf("v%0d_halted", v), {31'h0, halted},    32'h0);
      m_ready = 1'b1;
      wait_drain($sformatf("v%0d_drain_timeout", v));
      chk($sformatf("v%0d_re_total", v), re_cnt, vecs[v].nwr);
`ifdef FIFO_DRAIN_STATS_EN
      chk($sformatf("v%0d_stat_words", v), {16'h0, stat_words}, vecs[v].nwr);
`endif
    end

    // wr_evt in the same cycle as fifo_re with one word buffered
    begin
      bit found = 1'b0;
      do_reset();
      m_ready = 1'b1;
      wr_word(8'h11);
      for (int n = 0; n < 10 && !found; n++) begin
        if (fifo_re) found = 1'b1;
        else cycles(1);
      end
      chk("simul_re_seen", {31'h0, found}, 32'h1);
      chk("simul_occ_before", {28'h0, occupancy}, 32'h1);
      wr_word(8'h22);
      chk("simul_occ_after", {28'h0, occupancy}, 32'h1);
      wait_drain("simul_drain_timeout");
    end

    // read error: halt, no more RE, buffered words still delivered, clear
    begin
      int re_snap;
      do_reset();
      for (int i = 0; i < 8; i++) wr_word(8'(8'h30 + i));
      cycles(30);
      fifo_r_err = 1'b1;
      cycles(1);
      fifo_r_err = 1'b0;
      chk("err_halted", {31'h0, halted}, 32'h1);
      chk("err_state", {30'h0, dbg_state}, {30'h0, HALT});
      re_snap = re_cnt;
      m_ready = 1'b1;
      cycles(15);
      chk("err_no_re", re_cnt, re_snap);
      chk("err_delivered", exp_q.size(), 4);
      chk("err_obuf_empty", {31'h0, m_valid}, 32'h0);
`ifdef FIFO_DRAIN_STATS_EN
      chk("err_stat_errs", {24'h0, stat_errs}, 32'h1);
`endif
      clear_err = 1'b1;
      cycles(1);
      clear_err = 1'b0;
      chk("clr_occ", {28'h0, occupancy}, 32'h0);
      chk("clr_state", {30'h0, dbg_state}, {30'h0, IDLE});
      chk("clr_halted", {31'h0, halted}, 32'h0);
      exp_q.delete();
    end

    // spurious read_valid with nothing in flight
    do_reset();
    force_d = 8'h5A;
    force_rv = 1'b1;
    cycles(1);
    force_rv = 1'b0;
    chk("spur_halted", {31'h0, halted}, 32'h1);
    chk("spur_stored", {31'h0, m_valid}, 32'h1);
    chk("spur_data", {24'h0, m_data}, 32'h5A);
`ifdef FIFO_DRAIN_STATS_EN
    chk("spur_stat_errs", {24'h0, stat_errs}, 32'h1);
`endif
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
    chk("spur_clr_state", {30'h0, dbg_state}, {30'h0, IDLE});
    exp_q.push_back(8'h5A);
    m_ready = 1'b1;
    cycles(5);
    chk("spur_drained", exp_q.size(), 0);

    // reset mid-burst with two words held in the output buffer
    do_reset();
    wr_word(8'hD1);
    wr_word(8'hD2);
    cycles(10);
    chk("mid_valid_before", {31'h0, m_valid}, 32'h1);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    exp_q.delete();
    chk("mid_valid_after", {31'h0, m_valid}, 32'h0);
    chk("mid_occ_after", {28'h0, occupancy}, 32'h0);
    chk("mid_data_after", {24'h0, m_data}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
